// File: rtl/rob.sv
// rtl/rob.sv - circular reorder buffer with in-order single retirement
//
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   alloc_*                 : allocation request at the tail; alloc_ready/alloc_tag report slot
//   complete_valid/_tag     : marks an allocated entry as executed
//   retire_*                : registered one-cycle pulse with the freed mapping of the head entry
//   count, full, empty      : occupancy derived from the registered counter
module rob #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic [5:0]       alloc_phys_rd,
  input  logic [5:0]       alloc_old_phys_rd,
  input  logic [4:0]       alloc_arch_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  output logic             retire_valid,
  output logic [5:0]       retire_phys_reg,
  output logic [4:0]       retire_arch_rd,
  output logic [TAG_W-1:0] retire_tag,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE   = TAG_W'(1);

  // Per-entry state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] has_rd_q, has_rd_d;
  logic [5:0]       phys_rd_q [DEPTH];
  logic [5:0]       phys_rd_d [DEPTH];
  logic [5:0]       old_phys_rd_q [DEPTH];
  logic [5:0]       old_phys_rd_d [DEPTH];
  logic [4:0]       arch_rd_q [DEPTH];
  logic [4:0]       arch_rd_d [DEPTH];

  // Pointers and occupancy
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Registered retire port
  logic             retire_valid_q, retire_valid_d;
  logic [5:0]       retire_phys_reg_q, retire_phys_reg_d;
  logic [4:0]       retire_arch_rd_q, retire_arch_rd_d;
  logic [TAG_W-1:0] retire_tag_q, retire_tag_d;

  logic do_alloc;
  logic do_retire;

  // The new physical register is carried along with the entry for visibility
  // but is not needed when the entry retires.
  logic unused_phys_rd;
  assign unused_phys_rd = ^phys_rd_q[head_q];

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  // Readiness comes from the registered count only, so a retirement out of a
  // full buffer frees the slot for the next edge, not the current one.
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  assign retire_valid    = retire_valid_q;
  assign retire_phys_reg = retire_phys_reg_q;
  assign retire_arch_rd  = retire_arch_rd_q;
  assign retire_tag      = retire_tag_q;

  assign do_alloc  = alloc_valid && !full;
  // Uses the registered done bit, so a completion never retires on its own edge.
  assign do_retire = valid_q[head_q] && done_q[head_q];

  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    has_rd_d      = has_rd_q;
    phys_rd_d     = phys_rd_q;
    old_phys_rd_d = old_phys_rd_q;
    arch_rd_d     = arch_rd_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    retire_valid_d    = 1'b0;
    retire_phys_reg_d = retire_phys_reg_q;
    retire_arch_rd_d  = retire_arch_rd_q;
    retire_tag_d      = retire_tag_q;

    // Completion of a free slot is dropped so a later allocation starts clean.
    if (complete_valid && valid_q[complete_tag]) begin
      done_d[complete_tag] = 1'b1;
    end

    if (do_retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + PTR_ONE;
      retire_valid_d  = 1'b1;
      retire_tag_d    = head_q;
      if (has_rd_q[head_q]) begin
        retire_phys_reg_d = old_phys_rd_q[head_q];
        retire_arch_rd_d  = arch_rd_q[head_q];
      end else begin
        retire_phys_reg_d = 6'h3F;
        retire_arch_rd_d  = 5'h1F;
      end
    end

    // The tail slot is free whenever allocation is allowed, so it never
    // collides with the head entry being retired.
    if (do_alloc) begin
      valid_d[tail_q]       = 1'b1;
      done_d[tail_q]        = 1'b0;
      has_rd_d[tail_q]      = alloc_has_rd;
      phys_rd_d[tail_q]     = alloc_phys_rd;
      old_phys_rd_d[tail_q] = alloc_old_phys_rd;
      arch_rd_d[tail_q]     = alloc_arch_rd;
      tail_d                = tail_q + PTR_ONE;
    end

    case ({do_alloc, do_retire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q           <= '0;
      done_q            <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      retire_valid_q    <= 1'b0;
      retire_phys_reg_q <= 6'h3F;
      retire_arch_rd_q  <= 5'h1F;
      retire_tag_q      <= '0;
    end else begin
      valid_q           <= valid_d;
      done_q            <= done_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      retire_valid_q    <= retire_valid_d;
      retire_phys_reg_q <= retire_phys_reg_d;
      retire_arch_rd_q  <= retire_arch_rd_d;
      retire_tag_q      <= retire_tag_d;
    end
  end

  // Payload fields are only meaningful while valid is set, so they need no reset.
  always_ff @(posedge clk) begin
    has_rd_q      <= has_rd_d;
    phys_rd_q     <= phys_rd_d;
    old_phys_rd_q <= old_phys_rd_d;
    arch_rd_q     <= arch_rd_d;
  end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - self-checking bench for rob: vector table, corner sequences, random vs queue model
module tb_rob;

  logic       clk;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_has_rd;
  logic [5:0] alloc_phys_rd;
  logic [5:0] alloc_old_phys_rd;
  logic [4:0] alloc_arch_rd;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       complete_valid;
  logic [3:0] complete_tag;
  logic       retire_valid;
  logic [5:0] retire_phys_reg;
  logic [4:0] retire_arch_rd;
  logic [3:0] retire_tag;
  logic [4:0] count;
  logic       full;
  logic       empty;

  rob #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd),
    .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys_rd(alloc_old_phys_rd),
    .alloc_arch_rd(alloc_arch_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .retire_valid(retire_valid), .retire_phys_reg(retire_phys_reg),
    .retire_arch_rd(retire_arch_rd), .retire_tag(retire_tag),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program-ordered queue of live instructions
  typedef struct {
    logic [3:0] tag;
    logic       has_rd;
    logic [5:0] old;
    logic [4:0] arch;
    logic       done;
  } ent_t;

  ent_t mq[$];
  int   mtail;
  logic e_rv;
  logic e_fchk;
  logic [5:0] e_rphys;
  logic [4:0] e_rarch;
  logic [3:0] e_rtag;

  typedef struct {
    logic       rst;
    logic       av;
    logic       hrd;
    logic [5:0] ph;
    logic [5:0] od;
    logic [4:0] ar;
    logic       cv;
    logic [3:0] ct;
    logic       erv;
    logic [5:0] eph;
    logic [4:0] ear;
    logic [3:0] etag;
    logic [4:0] ecnt;
    logic       fchk;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by one edge, then compare DUT to model.
  task automatic cycle(input logic r, input logic av, input logic hrd,
                       input logic [5:0] ph, input logic [5:0] od, input logic [4:0] ar,
                       input logic cv, input logic [3:0] ct);
    int   pre_size;
    logic do_ret;
    ent_t h;
    ent_t e;
    reset = r; alloc_valid = av; alloc_has_rd = hrd; alloc_phys_rd = ph;
    alloc_old_phys_rd = od; alloc_arch_rd = ar; complete_valid = cv; complete_tag = ct;
    if (r) begin
      mq.delete();
      mtail = 0;
      e_rv = 1'b0; e_fchk = 1'b1; e_rphys = 6'h3F; e_rarch = 5'h1F; e_rtag = 4'd0;
    end else begin
      pre_size = mq.size();
      do_ret = (pre_size > 0) && mq[0].done;
      if (cv) begin
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].tag == ct) mq[i].done = 1'b1;
      end
      e_rv = do_ret;
      e_fchk = do_ret;
      if (do_ret) begin
        h = mq.pop_front();
        e_rtag  = h.tag;
        e_rphys = h.has_rd ? h.old : 6'h3F;
        e_rarch = h.has_rd ? h.arch : 5'h1F;
      end
      if (av && pre_size < 16) begin
        e.tag = 4'(mtail); e.has_rd = hrd; e.old = od; e.arch = ar; e.done = 1'b0;
        mq.push_back(e);
        mtail = (mtail + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 16));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 16));
    chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
    chk("retire_valid", 32'(retire_valid), 32'(e_rv));
    if (e_fchk) begin
      chk("retire_phys_reg", 32'(retire_phys_reg), 32'(e_rphys));
      chk("retire_arch_rd", 32'(retire_arch_rd), 32'(e_rarch));
      chk("retire_tag", 32'(retire_tag), 32'(e_rtag));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 4'd0);
  endtask

  task automatic alloc(input logic hrd, input logic [5:0] ph, input logic [5:0] od, input logic [4:0] ar);
    cycle(1'b0, 1'b1, hrd, ph, od, ar, 1'b0, 4'd0);
  endtask

  task automatic comp(input logic [3:0] t);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 5'd0, 1'b1, t);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 4'd0);
  endtask

  function automatic vec_t mk(input logic rst, input logic av, input logic hrd,
                              input logic [5:0] ph, input logic [5:0] od, input logic [4:0] ar,
                              input logic cv, input logic [3:0] ct,
                              input logic erv, input logic [5:0] eph, input logic [4:0] ear,
                              input logic [3:0] etag, input logic [4:0] ecnt, input logic fchk);
    vec_t v;
    v.rst = rst; v.av = av; v.hrd = hrd; v.ph = ph; v.od = od; v.ar = ar;
    v.cv = cv; v.ct = ct; v.erv = erv; v.eph = eph; v.ear = ear; v.etag = etag;
    v.ecnt = ecnt; v.fchk = fchk;
    return v;
  endfunction

  initial begin
    logic [3:0] ct;
    logic       cv;
    reset = 1'b1; alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_phys_rd = '0;
    alloc_old_phys_rd = '0; alloc_arch_rd = '0; complete_valid = 1'b0; complete_tag = '0;
    mtail = 0; e_rv = 1'b0; e_fchk = 1'b0; e_rphys = 6'h3F; e_rarch = 5'h1F; e_rtag = 4'd0;

    // Single instruction lifecycle, then out-of-order completion with in-order retire
    vecs.push_back(mk(1,0,0, 0, 0,0, 0,0, 0,6'h3F,5'h1F,0, 0,1));
    vecs.push_back(mk(0,1,1,32, 5,5, 0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 1,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 1,5,5,0, 0,1));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0, 0,0, 0,0, 0,6'h3F,5'h1F,0, 0,1));
    vecs.push_back(mk(0,1,1,10, 1,1, 0,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0,1,1,11, 2,2, 0,0, 0,0,0,0, 2,0));
    vecs.push_back(mk(0,1,0,12, 3,3, 0,0, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 1,2, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 1,1, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 1,0, 0,0,0,0, 3,0));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 1,1,1,0, 2,1));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 1,2,2,1, 1,1));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 1,6'h3F,5'h1F,2, 0,1));
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0, 0,0,0,0, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].av, vecs[i].hrd, vecs[i].ph, vecs[i].od, vecs[i].ar,
            vecs[i].cv, vecs[i].ct);
      chk($sformatf("vec%0d_retire_valid", i), 32'(retire_valid), 32'(vecs[i].erv));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      if (vecs[i].fchk) begin
        chk($sformatf("vec%0d_phys", i), 32'(retire_phys_reg), 32'(vecs[i].eph));
        chk($sformatf("vec%0d_arch", i), 32'(retire_arch_rd), 32'(vecs[i].ear));
        chk($sformatf("vec%0d_tag", i), 32'(retire_tag), 32'(vecs[i].etag));
      end
    end

    // Fill to capacity, overflow attempt, then retire-gated reallocation with wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1'b1, 6'(i + 32), 6'(i), 5'(i));
    chk("full_after_16", 32'(full), 32'd1);
    chk("ready_after_16", 32'(alloc_ready), 32'd0);
    alloc(1'b1, 6'd60, 6'd61, 5'd30);
    chk("count_after_17th", 32'(count), 32'd16);
    cycle(1'b0, 1'b1, 1'b1, 6'd60, 6'd61, 5'd30, 1'b1, 4'd0);
    chk("count_complete_edge", 32'(count), 32'd16);
    alloc(1'b1, 6'd60, 6'd61, 5'd30);
    chk("count_retire_edge", 32'(count), 32'd15);
    chk("wrap_alloc_tag", 32'(alloc_tag), 32'd0);
    alloc(1'b1, 6'd60, 6'd61, 5'd30);
    chk("count_after_realloc", 32'(count), 32'd16);

    // Steady state: one alloc and one retire per edge across the pointer wrap
    do_reset();
    alloc(1'b1, 6'd1, 6'd1, 5'd1);
    alloc(1'b1, 6'd2, 6'd2, 5'd2);
    for (int i = 0; i < 24; i++) begin
      ct = mq[0].done ? mq[1].tag : mq[0].tag;
      cycle(1'b0, 1'b1, 1'b1, 6'(i), 6'(i + 3), 5'(i), 1'b1, ct);
      if (i >= 1) chk("steady_count", 32'(count), 32'd3);
    end

    // Completion of an unallocated tag is ignored
    do_reset();
    comp(4'd7);
    chk("ghost_complete_count", 32'(count), 32'd0);
    chk("ghost_complete_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 8; i++) alloc(1'b0, 6'd0, 6'd0, 5'd0);
    for (int i = 0; i < 7; i++) comp(4'(i));
    for (int i = 0; i < 3; i++) idle();
    chk("tag7_not_done", 32'(count), 32'd1);

    // Reset with live and done entries discards everything silently
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1, 6'(i), 6'(i), 5'(i));
    comp(4'd2);
    comp(4'd3);
    do_reset();
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_reset_no_retire", 32'(retire_valid), 32'd0);
    end
    chk("post_reset_count", 32'(count), 32'd0);

    // Random traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cv = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ct = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ct = 4'($urandom);
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom), 6'($urandom), 6'($urandom), 5'($urandom), cv, ct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
